edge_event_arbiter: RTL
=======================

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 The block SHALL have parameter N_CH, default 4: number of monitored input channels, range 2..16.
REQ-002 The block SHALL have parameter NEG, default 1: 1 = falling-edge events, 0 = rising-edge events.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port sig, input, N_CH bits: monitored level signals.
REQ-006 The block SHALL have port en, input, N_CH bits: per-channel event enable.
REQ-007 The block SHALL have port ev_valid, output, 1 bit: an event is offered.
REQ-008 The block SHALL have port ev_ready, input, 1 bit: the consumer accepts the offered event.
REQ-009 The block SHALL have port ev_ch, output, clog2(N_CH) bits: index of the offered channel.
REQ-010 The block SHALL have port ev_overrun, output, N_CH bits: sticky per-channel lost-event flags.
REQ-011 The block SHALL have port clr_overrun, input, 1 bit: clears all overrun flags.

Function
REQ-012 The block SHALL register each channel's sampled level in sig_dly every cycle; edge[i] = NEG ? (sig_dly[i] & ~s[i]) : (~sig_dly[i] & s[i]), where s is the sampled input.
REQ-013 An edge on channel i with en[i]=1 SHALL set pending[i] on the next clock edge; with en[i]=0 the edge SHALL be discarded.
REQ-014 An edge on channel i while pending[i]=1 and not being accepted this cycle SHALL set ev_overrun[i]; pending[i] SHALL remain 1.
REQ-015 The FSM SHALL have states IDLE and OFFER; in IDLE with any pending bit set, it SHALL load ev_ch with the round-robin winner, assert ev_valid, and go to OFFER.
REQ-016 Round-robin priority SHALL start at (last_grant+1) mod N_CH and search upward with wrap-around; last_grant resets to N_CH-1, so channel 0 wins first.
REQ-017 In OFFER, ev_ch and ev_valid SHALL hold stable until ev_ready=1; on acceptance pending[ev_ch] SHALL clear, last_grant SHALL load ev_ch, ev_valid SHALL deassert, and the FSM SHALL return to IDLE.
REQ-018 Throughput SHALL be at most one event per 2 cycles; latency from the edge on s to ev_valid SHALL be 2 cycles when idle.
REQ-019 If an edge on the offered channel coincides with acceptance, pending SHALL stay set (new event) and no overrun SHALL be flagged.
REQ-020 Clearing en[i] SHALL clear pending[i] on the next edge unless channel i is currently offered; an offered event SHALL complete normally.
REQ-021 clr_overrun SHALL clear all ev_overrun bits; an overrun set in the same cycle SHALL win for that bit.

Reset
REQ-022 While rst_n=0: ev_valid=0, ev_ch=0, ev_overrun=0, pending=0, state=IDLE, last_grant=N_CH-1, and sig_dly (and synchronizer flops) = idle level (all 1 if NEG=1, all 0 if NEG=0).
REQ-023 Reset asserted mid-OFFER SHALL drop the event without acceptance; no edge SHALL be reported in the first cycle after reset release unless s differs from the idle level and forms a valid edge.

Configuration
REQ-024 With macro EDGE_EVENT_ARB_SYNC_EN defined, s SHALL be sig passed through a 2-flop synchronizer per channel, adding 2 cycles of latency (4 total).
REQ-025 Without EDGE_EVENT_ARB_SYNC_EN, s SHALL equal sig directly (sig is synchronous to clk).

Structure
REQ-026 The FSM state encoding (IDLE, OFFER) and the default N_CH SHALL live in shared package edge_event_arb_pkg.
REQ-027 Per-channel sampling, synchronization and edge detection SHALL be a sub-module, sync_edge_det, instantiated N_CH times; arbitration and the FSM SHALL live in the top module.

Verification
REQ-028 Scenario 1: NEG=1, en=4'hF, ev_ready=1; sig[2] 1->0 -> ev_valid=1 with ev_ch=2 exactly 2 cycles later (4 with SYNC_EN), then pending[2]=0.
REQ-029 Scenario 2: falling edges on channels 0, 1 and 3 in the same cycle, ev_ready=1 -> grants in the order 0, 1, 3 on alternate cycles; ev_overrun=0.
REQ-030 Scenario 3: ev_ready=0, two falling edges on channel 1 spaced 4 cycles apart -> ev_overrun=4'b0010, ev_ch=1 held stable; clr_overrun=1 -> ev_overrun=0.
REQ-031 Scenario 4: en=4'b1011, falling edge on channel 2 -> ev_valid stays 0 for 10 cycles.
REQ-032 Scenario 5: rst_n pulsed low while in OFFER with ev_ch=3 -> ev_valid=0 immediately (asynchronous); after release, no event is generated with sig held all-1.
REQ-033 Scenario 6: edge on the offered channel 0 in the same cycle as ev_ready=1 -> channel 0 is offered again 1 cycle after returning to IDLE; ev_overrun[0]=0.

Source files
------------

// File: rtl/edge_event_arb_pkg.sv
// Shared FSM encoding and default channel count for the edge event arbiter.
package edge_event_arb_pkg;

   localparam int N_CH_DEFAULT = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } arb_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// One channel: optional 2-flop synchronizer (EDGE_EVENT_ARB_SYNC_EN), delayed sample and edge detect.
// All flops reset to the idle level so reset release never fakes an edge.
module sync_edge_det #(
   parameter bit NEG = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_in,
   output logic edge_out
);

   localparam logic IDLE_LVL = NEG;

   logic s;
   logic sig_dly_q, sig_dly_d;

`ifdef EDGE_EVENT_ARB_SYNC_EN
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;

   always_comb begin
      sync1_d = sig_in;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= IDLE_LVL;
         sync2_q <= IDLE_LVL;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign s = sync2_q;
`else
   assign s = sig_in;
`endif

   always_comb sig_dly_d = s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sig_dly_q <= IDLE_LVL;
      else        sig_dly_q <= sig_dly_d;
   end

   assign edge_out = NEG ? (sig_dly_q & ~s) : (~sig_dly_q & s);

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: per-channel edge capture, round-robin selection, valid/ready offer.
// Define EDGE_EVENT_ARB_SYNC_EN to synchronize sig inside each channel (2 extra cycles latency).
//   state | meaning
//   IDLE  | no event offered; loads the round-robin winner when anything is pending
//   OFFER | ev_valid high, ev_ch held until ev_ready
module edge_event_arbiter
   import edge_event_arb_pkg::*;
#(
   parameter int N_CH = N_CH_DEFAULT,
   parameter int NEG  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_CH-1:0]         sig,
   input  logic [N_CH-1:0]         en,
   output logic                    ev_valid,
   input  logic                    ev_ready,
   output logic [$clog2(N_CH)-1:0] ev_ch,
   output logic [N_CH-1:0]         ev_overrun,
   input  logic                    clr_overrun
);

   localparam int CW = $clog2(N_CH);

   arb_state_e      state_q, state_d;
   logic            ev_valid_q, ev_valid_d;
   logic [CW-1:0]   ev_ch_q, ev_ch_d;
   logic [CW-1:0]   last_grant_q, last_grant_d;
   logic [N_CH-1:0] pending_q, pending_d;
   logic [N_CH-1:0] ev_overrun_q, ev_overrun_d;
   logic [N_CH-1:0] edge_det;
   logic [CW-1:0]   win;
   logic            found;
   int              cand;
   logic            offered;
   logic            accept;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      sync_edge_det #(.NEG(NEG != 0)) u_det (
         .clk      (clk),
         .rst_n    (rst_n),
         .sig_in   (sig[i]),
         .edge_out (edge_det[i])
      );
   end

   // Search starts just above the last grant and wraps.
   always_comb begin
      win   = '0;
      found = 1'b0;
      cand  = 0;
      for (int k = 1; k <= N_CH; k++) begin
         cand = int'(last_grant_q) + k;
         if (cand >= N_CH) cand = cand - N_CH;
         if (!found && pending_q[CW'(cand)]) begin
            found = 1'b1;
            win   = CW'(cand);
         end
      end
   end

   // A new edge beats acceptance, and a set overrun beats the clear.
   always_comb begin
      pending_d    = pending_q;
      ev_overrun_d = clr_overrun ? '0 : ev_overrun_q;
      offered      = 1'b0;
      accept       = 1'b0;
      for (int j = 0; j < N_CH; j++) begin
         offered = (state_q == OFFER) && (ev_ch_q == CW'(j));
         accept  = offered && ev_ready;
         if (edge_det[CW'(j)] && en[CW'(j)]) begin
            pending_d[CW'(j)] = 1'b1;
            if (pending_q[CW'(j)] && !accept) ev_overrun_d[CW'(j)] = 1'b1;
         end else if (accept || (!en[CW'(j)] && !offered)) begin
            pending_d[CW'(j)] = 1'b0;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      ev_valid_d   = ev_valid_q;
      ev_ch_d      = ev_ch_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (|pending_q) begin
               state_d    = OFFER;
               ev_valid_d = 1'b1;
               ev_ch_d    = win;
            end
         end
         OFFER: begin
            if (ev_ready) begin
               state_d      = IDLE;
               ev_valid_d   = 1'b0;
               last_grant_d = ev_ch_q;
            end
         end
         default: begin
            state_d    = IDLE;
            ev_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ev_valid_q   <= 1'b0;
         ev_ch_q      <= '0;
         last_grant_q <= CW'(N_CH - 1);
         pending_q    <= '0;
         ev_overrun_q <= '0;
      end else begin
         state_q      <= state_d;
         ev_valid_q   <= ev_valid_d;
         ev_ch_q      <= ev_ch_d;
         last_grant_q <= last_grant_d;
         pending_q    <= pending_d;
         ev_overrun_q <= ev_overrun_d;
      end
   end

   assign ev_valid   = ev_valid_q;
   assign ev_ch      = ev_ch_q;
   assign ev_overrun = ev_overrun_q;

endmodule
